dma_r_shortcut_nsrc: RTL

//  DMA-read shortcut engine, generalised: external memory -> OCM with an N-source element-wise residual add.

---
 rtl/dma_r_shortcut_nsrc_if.sv | 50 +++++
 rtl/dma_r_shortcut_nsrc.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dma_r_shortcut_nsrc_if.sv
// Bus bundle for the N-source shortcut engine: config, read request,
// read data, OCM write and status.
interface dma_r_shortcut_nsrc_if #(
  parameter int AXI_DW = 128,
  parameter int NSRC   = 2
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [NSRC*32-1:0]  cfg_src_sa;
  logic [31:0]         cfg_dst_sa;
  logic [31:0]         cfg_len;
  logic                cfg_wrap;
  logic                dmar_valid;
  logic                dmar_ready;
  logic [31:0]         dmar_sa;
  logic [31:0]         dmar_len;
  logic [AXI_DW-1:0]   dma_rdata;
  logic                dma_rlast;
  logic                dma_rvalid;
  logic                dma_rready;
  logic                ram_we;
  logic [31:0]         ram_a;
  logic [AXI_DW-1:0]   ram_d;
  logic                done;
  logic                err_rlast;

  modport slave (
    input  cfg_valid, cfg_src_sa, cfg_dst_sa,
    input  cfg_len, cfg_wrap,
    output cfg_ready,
    output dmar_valid, dmar_sa, dmar_len,
    input  dmar_ready,
    input  dma_rdata, dma_rlast, dma_rvalid,
    output dma_rready,
    output ram_we, ram_a, ram_d,
    output done, err_rlast
  );

  modport master (
    output cfg_valid, cfg_src_sa, cfg_dst_sa,
    output cfg_len, cfg_wrap,
    input  cfg_ready,
    input  dmar_valid, dmar_sa, dmar_len,
    output dmar_ready,
    output dma_rdata, dma_rlast, dma_rvalid,
    input  dma_rready,
    input  ram_we, ram_a, ram_d,
    input  done, err_rlast
  );
endinterface

// File: rtl/dma_r_shortcut_nsrc.sv
// DMA-read shortcut engine: reads NSRC sources chunk by chunk,
// adds them lane-wise (wrap or saturate) and writes the sums to OCM.
module dma_r_shortcut_nsrc #(
  parameter int AXI_DW      = 128,
  parameter int ELEM_W      = 16,
  parameter int NSRC        = 2,
  parameter int CHUNK_BEATS = 16
) (
  input logic usr_clk,
  input logic usr_reset,
  dma_r_shortcut_nsrc_if.slave bus
);
  localparam int LANES = AXI_DW / ELEM_W;
  localparam int BYTES = AXI_DW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = $clog2(CHUNK_BEATS) + 1;
  localparam int IW    = (CHUNK_BEATS > 1) ? $clog2(CHUNK_BEATS) : 1;
  localparam int SW    = $clog2(NSRC);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t            state, state_nx;
  logic [31:0]       src_sa [NSRC];
  logic [31:0]       dst_sa;
  logic [31:0]       total;
  logic [31:0]       off;
  logic [SW-1:0]     src;
  logic [CW-1:0]     beat;
  logic              mode;
  logic [AXI_DW-1:0] chunk_buf [CHUNK_BEATS];

  logic [31:0]       rem;
  logic [31:0]       off_nx;
  logic [31:0]       cfg_total;
  logic [CW-1:0]     cb;
  logic              cfg_acc;
  logic              beat_acc;
  logic              last_beat;
  logic              last_src;
  logic [AXI_DW-1:0] sum;

  function automatic logic [AXI_DW-1:0] vec_add(
    input logic [AXI_DW-1:0] a,
    input logic [AXI_DW-1:0] b,
    input logic              wrap
  );
    logic [AXI_DW-1:0] r;
    logic [ELEM_W:0]   s;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      s = {a[l*ELEM_W+ELEM_W-1], a[l*ELEM_W +: ELEM_W]}
        + {b[l*ELEM_W+ELEM_W-1], b[l*ELEM_W +: ELEM_W]};
      // sign bits disagree only on overflow; clamp toward its direction
      if (wrap || (s[ELEM_W] == s[ELEM_W-1]))
        r[l*ELEM_W +: ELEM_W] = s[ELEM_W-1:0];
      else
        r[l*ELEM_W +: ELEM_W] = {s[ELEM_W], {(ELEM_W-1){~s[ELEM_W]}}};
    end
    return r;
  endfunction

  assign cfg_total = bus.cfg_len >> BSH;
  assign rem       = total - off;
  assign cb        = (rem >= 32'(CHUNK_BEATS)) ? CW'(CHUNK_BEATS)
                                               : rem[CW-1:0];
  assign off_nx    = off + 32'(cb);
  assign cfg_acc   = bus.cfg_valid && (state == IDLE);
  assign beat_acc  = bus.dma_rvalid && (state == DATA);
  assign last_beat = (beat == cb - CW'(1));
  assign last_src  = (src == SW'(NSRC - 1));
  assign sum       = vec_add(chunk_buf[beat[IW-1:0]], bus.dma_rdata, mode);

  always_ff @(posedge usr_clk) begin
    if (usr_reset) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cfg_acc)
              state_nx = (cfg_total == '0) ? DONE : REQ;
      REQ:  if (bus.dmar_ready) state_nx = DATA;
      DATA: if (beat_acc && last_beat)
              state_nx = (last_src && off_nx == total) ? DONE : REQ;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.cfg_ready  = (state == IDLE);
  assign bus.dmar_valid = (state == REQ);
  assign bus.dma_rready = (state == DATA);
  assign bus.done       = (state == DONE);
  assign bus.dmar_sa    = (state == REQ) ? src_sa[src] + (off << BSH) : '0;
  assign bus.dmar_len   = (state == REQ) ? (32'(cb) << BSH) : '0;

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      for (int k = 0; k < NSRC; k++) src_sa[k] <= '0;
      dst_sa        <= '0;
      total         <= '0;
      off           <= '0;
      src           <= '0;
      beat          <= '0;
      mode          <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_a     <= '0;
      bus.ram_d     <= '0;
      bus.err_rlast <= 1'b0;
    end else begin
      bus.ram_we <= 1'b0;
      if (cfg_acc) begin
        for (int k = 0; k < NSRC; k++)
          src_sa[k] <= bus.cfg_src_sa[32*k +: 32];
        dst_sa        <= bus.cfg_dst_sa;
        total         <= cfg_total;
        off           <= '0;
        src           <= '0;
        beat          <= '0;
        mode          <= bus.cfg_wrap;
        bus.err_rlast <= 1'b0;
      end
      if (beat_acc) begin
        // beat count rules; rlast only flags disagreement
        if (bus.dma_rlast != last_beat) bus.err_rlast <= 1'b1;
        if (last_src) begin
          bus.ram_we <= 1'b1;
          bus.ram_d  <= sum;
          bus.ram_a  <= dst_sa + ((off + 32'(beat)) << BSH);
        end
        if (last_beat) begin
          beat <= '0;
          if (last_src) begin
            src <= '0;
            off <= off_nx;
          end else begin
            src <= src + SW'(1);
          end
        end else begin
          beat <= beat + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge usr_clk) begin
    if (beat_acc && !last_src)
      chunk_buf[beat[IW-1:0]] <= (src == '0) ? bus.dma_rdata : sum;
  end
endmodule
